// File: rtl/sync_debounce_edge.sv
// Synchronizes a raw asynchronous level, debounces it with a stable-count FSM, and emits
// a clean level plus one-cycle rise/fall pulses. Optional abort counter: SYNC_DEBOUNCE_GLITCH_CNT_EN.
module sync_debounce_edge #(
  parameter int unsigned SYNC_STAGES  = 2,
  parameter int unsigned CNT_W        = 16,
  parameter int unsigned DEBOUNCE_CNT = 1000
) (
  input  logic clk,
  input  logic rst,
  input  logic en,
  input  logic din,
`ifdef SYNC_DEBOUNCE_GLITCH_CNT_EN
  input  logic       glitch_clr,
  output logic [7:0] glitch_cnt,
`endif
  output logic dout,
  output logic rise,
  output logic fall,
  output logic busy
);

  localparam logic [CNT_W-1:0] CNT_MAX = CNT_W'(DEBOUNCE_CNT);
  localparam logic [CNT_W-1:0] CNT_ONE = CNT_W'(1);

  typedef enum logic [1:0] {
    IDLE_LO = 2'd0,
    WAIT_HI = 2'd1,
    IDLE_HI = 2'd2,
    WAIT_LO = 2'd3
  } state_t;

  logic [SYNC_STAGES-1:0] sync_q;
  logic                   s;
  state_t                 state_q, state_d;
  logic [CNT_W-1:0]       cnt_q, cnt_d;
  logic                   dout_d, rise_d, fall_d, busy_d;

  // Synchronizer chain; only the last stage is observed
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) sync_q <= '0;
    else      sync_q <= {sync_q[SYNC_STAGES-2:0], din};
  end

  assign s = sync_q[SYNC_STAGES-1];

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state_q <= IDLE_LO;
      cnt_q   <= '0;
      dout    <= 1'b0;
      rise    <= 1'b0;
      fall    <= 1'b0;
      busy    <= 1'b0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
      dout    <= dout_d;
      rise    <= rise_d;
      fall    <= fall_d;
      busy    <= busy_d;
    end
  end

  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q;
    dout_d  = dout;
    rise_d  = 1'b0;
    fall_d  = 1'b0;
    if (!en) begin
      // Disabled: drop any pending candidate, fall back to the idle state of the held level
      if (state_q == WAIT_HI || state_q == WAIT_LO) begin
        state_d = dout ? IDLE_HI : IDLE_LO;
        cnt_d   = '0;
      end
    end else begin
      case (state_q)
        IDLE_LO: begin
          if (s) begin
            state_d = WAIT_HI;
            cnt_d   = CNT_ONE;
          end
        end
        WAIT_HI: begin
          if (!s) begin
            state_d = IDLE_LO;
            cnt_d   = '0;
          end else if (cnt_q == CNT_MAX) begin
            state_d = IDLE_HI;
            cnt_d   = '0;
            dout_d  = 1'b1;
            rise_d  = 1'b1;
          end else begin
            cnt_d = cnt_q + CNT_ONE;
          end
        end
        IDLE_HI: begin
          if (!s) begin
            state_d = WAIT_LO;
            cnt_d   = CNT_ONE;
          end
        end
        WAIT_LO: begin
          if (s) begin
            state_d = IDLE_HI;
            cnt_d   = '0;
          end else if (cnt_q == CNT_MAX) begin
            state_d = IDLE_LO;
            cnt_d   = '0;
            dout_d  = 1'b0;
            fall_d  = 1'b1;
          end else begin
            cnt_d = cnt_q + CNT_ONE;
          end
        end
        default: begin
          state_d = IDLE_LO;
          cnt_d   = '0;
        end
      endcase
    end
    busy_d = (state_d == WAIT_HI) || (state_d == WAIT_LO);
  end

`ifdef SYNC_DEBOUNCE_GLITCH_CNT_EN
  logic abort_c;

  // Only reversions of s count as glitches; enable-driven aborts are excluded
  assign abort_c = en && (((state_q == WAIT_HI) && !s) || ((state_q == WAIT_LO) && s));

  always_ff @(posedge clk or negedge rst) begin
    if (!rst)                              glitch_cnt <= 8'd0;
    else if (glitch_clr)                   glitch_cnt <= 8'd0;
    else if (abort_c && glitch_cnt != 8'hff) glitch_cnt <= glitch_cnt + 8'd1;
  end
`endif

endmodule

// File: tb/tb_sync_debounce_edge.sv
// Self-checking bench for sync_debounce_edge: stable-run-length reference model plus
// directed latency/glitch/enable scenarios and randomized din/en traffic.
module tb_sync_debounce_edge;

  localparam int unsigned SS = 2;
  localparam int unsigned DC = 4;

  logic clk = 1'b0;
  logic rst;
  logic en;
  logic din;
  logic dout, rise, fall, busy;
`ifdef SYNC_DEBOUNCE_GLITCH_CNT_EN
  logic       glitch_clr;
  logic [7:0] glitch_cnt;
`endif

  int errors = 0;
  int checks = 0;

  sync_debounce_edge #(.SYNC_STAGES(SS), .CNT_W(16), .DEBOUNCE_CNT(DC)) dut (
    .clk(clk),
    .rst(rst),
    .en(en),
    .din(din),
`ifdef SYNC_DEBOUNCE_GLITCH_CNT_EN
    .glitch_clr(glitch_clr),
    .glitch_cnt(glitch_cnt),
`endif
    .dout(dout),
    .rise(rise),
    .fall(fall),
    .busy(busy)
  );

  always #5 clk = ~clk;

  task automatic chk(input string name, input int act, input int exp);
    checks++;
    if (act != exp) begin
      errors++;
      $display("FAIL %s actual=%0d required=%0d at t=%0t", name, act, exp, $time);
    end
  endtask

  // Model: count consecutive enabled samples of s that differ from the accepted level;
  // the (DC+1)-th such sample flips the level.
  typedef struct packed {
    logic        dout;
    logic        rise;
    logic        fall;
    logic        busy;
    logic [7:0]  gl;
    logic [15:0] run;
  } mstate_t;

  function automatic mstate_t model_step(mstate_t m, logic s, logic e, logic clr);
    mstate_t n = m;
    n.rise = 1'b0;
    n.fall = 1'b0;
    if (!e) begin
      n.run = 16'd0;
    end else if (s != m.dout) begin
      n.run = m.run + 16'd1;
      if (n.run == 16'(DC + 1)) begin
        n.dout = s;
        n.rise = s;
        n.fall = !s;
        n.run  = 16'd0;
      end
    end else begin
      if (m.run != 16'd0 && m.gl != 8'd255) n.gl = m.gl + 8'd1;
      n.run = 16'd0;
    end
    if (clr) n.gl = 8'd0;
    n.busy = (n.run != 16'd0);
    return n;
  endfunction

  mstate_t         m;
  logic [SS-1:0]   m_dly;
  logic            clr_in;

`ifdef SYNC_DEBOUNCE_GLITCH_CNT_EN
  assign clr_in = glitch_clr;
`else
  assign clr_in = 1'b0;
`endif

  always @(posedge clk or negedge rst) begin
    if (!rst) begin
      m     <= '0;
      m_dly <= '0;
    end else begin
      m     <= model_step(m, m_dly[SS-1], en, clr_in);
      m_dly <= {m_dly[SS-2:0], din};
    end
  end

  // Per-cycle comparison against the model, away from the active edge
  always @(negedge clk) begin
    if (rst === 1'b1) begin
      chk("dout", int'(dout), int'(m.dout));
      chk("rise", int'(rise), int'(m.rise));
      chk("fall", int'(fall), int'(m.fall));
      chk("busy", int'(busy), int'(m.busy));
      chk("rise_fall_exclusive", int'(rise & fall), 0);
`ifdef SYNC_DEBOUNCE_GLITCH_CNT_EN
      chk("glitch_cnt", int'(glitch_cnt), int'(m.gl));
`endif
    end
  end

  int first_hit, pulse_n, other_n, busy_n, busy_last;

  // Hold din at lvl from a negedge and record per-edge activity over n edges
  task automatic track_edge(input logic lvl, input int n);
    first_hit = 0; pulse_n = 0; other_n = 0; busy_n = 0; busy_last = 0;
    @(negedge clk);
    din = lvl;
    for (int i = 1; i <= n; i++) begin
      @(posedge clk);
      #1;
      if (dout == lvl && first_hit == 0) first_hit = i;
      if (lvl ? rise : fall) pulse_n++;
      if (lvl ? fall : rise) other_n++;
      if (busy) begin
        busy_n++;
        busy_last = i;
      end
    end
  endtask

  int gl_before;

  initial begin
    rst = 1'b0;
    en  = 1'b1;
    din = 1'b0;
`ifdef SYNC_DEBOUNCE_GLITCH_CNT_EN
    glitch_clr = 1'b0;
`endif
    #23;
    chk("reset_dout", int'(dout), 0);
    chk("reset_busy", int'(busy), 0);
    @(negedge clk);
    #2 rst = 1'b1;

    // Async reset from a settled high level
    @(negedge clk);
    din = 1'b1;
    repeat (10) @(negedge clk);
    chk("pre_reset_dout", int'(dout), 1);
    #2 rst = 1'b0;
    #1;
    chk("async_rst_dout", int'(dout), 0);
    chk("async_rst_rise", int'(rise), 0);
    chk("async_rst_busy", int'(busy), 0);
    din = 1'b0;
    @(negedge clk);
    #2 rst = 1'b1;
    repeat (10) @(negedge clk);
    chk("post_reset_dout", int'(dout), 0);

    // Clean rise: dout after edge 7, busy on edges 3..6
    track_edge(1'b1, 20);
    chk("rise_latency", first_hit, 7);
    chk("rise_pulses", pulse_n, 1);
    chk("rise_no_fall", other_n, 0);
    chk("rise_busy_cycles", busy_n, 4);
    chk("rise_busy_last", busy_last, 6);

    // Clean fall
    track_edge(1'b0, 20);
    chk("fall_latency", first_hit, 7);
    chk("fall_pulses", pulse_n, 1);
    chk("fall_no_rise", other_n, 0);
    chk("fall_busy_cycles", busy_n, 4);

    // Glitch rejection: three-cycle high pulse
`ifdef SYNC_DEBOUNCE_GLITCH_CNT_EN
    gl_before = int'(glitch_cnt);
`endif
    @(negedge clk);
    din = 1'b1;
    repeat (3) @(negedge clk);
    track_edge(1'b0, 15);
    chk("glitch_no_rise", other_n, 0);
    chk("glitch_dout", int'(dout), 0);
    chk("glitch_busy_end", int'(busy), 0);
`ifdef SYNC_DEBOUNCE_GLITCH_CNT_EN
    chk("glitch_cnt_incr", int'(glitch_cnt), gl_before + 1);
`endif

    // Enable gating mid-qualification
    @(negedge clk);
    din = 1'b1;
    repeat (4) @(negedge clk);
    chk("en_busy_before", int'(busy), 1);
    en = 1'b0;
    @(negedge clk);
    chk("en_busy_dropped", int'(busy), 0);
    chk("en_dout_held", int'(dout), 0);
    pulse_n = 0;
    for (int i = 0; i < 10; i++) begin
      din = ~din;
      @(negedge clk);
      if (rise || fall || busy) pulse_n++;
    end
    chk("en_off_quiet", pulse_n, 0);
    din = 1'b1;
    repeat (4) @(negedge clk);
    en = 1'b1;
    first_hit = 0;
    for (int i = 1; i <= 8; i++) begin
      @(posedge clk);
      #1;
      if (dout && first_hit == 0) first_hit = i;
    end
    chk("reenable_latency", first_hit, 5);

    // Randomized runs of din with occasional enable drops
    for (int r = 0; r < 300; r++) begin
      @(negedge clk);
      din = 1'($urandom_range(0, 1));
      en  = ($urandom_range(0, 9) != 0);
      repeat ($urandom_range(0, 11)) @(negedge clk);
    end
    @(negedge clk);
    en = 1'b1;

`ifdef SYNC_DEBOUNCE_GLITCH_CNT_EN
    // Saturation: 300 two-cycle glitches from a settled low level
    din = 1'b0;
    repeat (12) @(negedge clk);
    for (int g = 0; g < 300; g++) begin
      din = 1'b1;
      repeat (2) @(negedge clk);
      din = 1'b0;
      repeat (3) @(negedge clk);
    end
    repeat (4) @(negedge clk);
    chk("glitch_cnt_saturated", int'(glitch_cnt), 255);
    // Clear held across a glitch abort wins over the increment
    glitch_clr = 1'b1;
    din = 1'b1;
    repeat (2) @(negedge clk);
    din = 1'b0;
    repeat (3) @(negedge clk);
    glitch_clr = 1'b0;
    @(negedge clk);
    chk("glitch_cnt_cleared", int'(glitch_cnt), 0);
`endif

    repeat (10) @(negedge clk);
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
